// File: rtl/inst_source_arbiter.sv
// Instruction-source arbiter: latches request edges as pending and
// grants one source per cycle (fixed priority or round-robin).
module inst_source_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 2,
  parameter int IDW     = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     halt,
  input  logic                     flush,
  input  logic                     rr_mode,
  output logic [WIDTH-1:0]         inst_out,
  output logic                     inst_valid,
  output logic [IDW-1:0]           grant_id,
  output logic [NUM_SRC-1:0]       pending,
  output logic [NUM_SRC-1:0]       overrun
);

  logic [NUM_SRC-1:0] r_req_d;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_ovr;
  logic [IDW-1:0]     r_ptr;
  logic [WIDTH-1:0]   r_inst;
  logic               r_valid;
  logic [IDW-1:0]     r_gid;

  logic [NUM_SRC-1:0] w_rise;
  logic               w_gnt;
  logic [IDW-1:0]     w_idx;
  logic [NUM_SRC-1:0] w_oh;
  logic [WIDTH-1:0]   w_data;

  assign w_rise = req & ~r_req_d;

  // Loops run backwards so the last hit is the first in search order.
  always_comb begin
    w_gnt = 1'b0;
    w_idx = '0;
    if (!flush && !halt) begin
      if (!rr_mode) begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (r_pend[i]) begin
            w_gnt = 1'b1;
            w_idx = IDW'(i);
          end
        end
      end else begin
        for (int k = NUM_SRC; k >= 1; k--) begin
          if (r_pend[(int'(r_ptr) + k) % NUM_SRC]) begin
            w_gnt = 1'b1;
            w_idx = IDW'((int'(r_ptr) + k) % NUM_SRC);
          end
        end
      end
    end
  end

  assign w_oh   = NUM_SRC'(w_gnt) << w_idx;
  assign w_data = src_data[int'(w_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_d <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
      r_ptr   <= IDW'(NUM_SRC - 1);
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_gid   <= '0;
    end else begin
      r_req_d <= req;
      r_valid <= w_gnt;
      if (w_gnt) begin
        r_inst <= w_data;
        r_gid  <= w_idx;
        r_ptr  <= w_idx;
      end
      if (flush) begin
        r_pend <= '0;
        r_ovr  <= '0;
      end else begin
        r_pend <= (r_pend & ~w_oh) | w_rise;
        r_ovr  <= r_ovr | (w_rise & r_pend & ~w_oh);
      end
    end
  end

  assign inst_out   = r_inst;
  assign inst_valid = r_valid;
  assign grant_id   = r_gid;
  assign pending    = r_pend;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_inst_source_arbiter.sv
// Directed bench for inst_source_arbiter with 2- and 3-source instances.
module tb_inst_source_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        reset2, halt2, flush2, rr2;
  logic [1:0]  req2;
  logic [31:0] data2;
  logic [15:0] inst2;
  logic        vld2;
  logic        gid2;
  logic [1:0]  pend2, ovr2;

  logic        reset3, halt3, flush3, rr3;
  logic [2:0]  req3;
  logic [47:0] data3;
  logic [15:0] inst3;
  logic        vld3;
  logic [1:0]  gid3;
  logic [2:0]  pend3, ovr3;

  inst_source_arbiter #(.WIDTH(16), .NUM_SRC(2)) u2 (
    .clk(clk), .reset(reset2), .req(req2), .src_data(data2),
    .halt(halt2), .flush(flush2), .rr_mode(rr2),
    .inst_out(inst2), .inst_valid(vld2), .grant_id(gid2),
    .pending(pend2), .overrun(ovr2)
  );

  inst_source_arbiter #(.WIDTH(16), .NUM_SRC(3)) u3 (
    .clk(clk), .reset(reset3), .req(req3), .src_data(data3),
    .halt(halt3), .flush(flush3), .rr_mode(rr3),
    .inst_out(inst3), .inst_valid(vld3), .grant_id(gid3),
    .pending(pend3), .overrun(ovr3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pulses;
  int seq_rr[6] = '{0, 1, 2, 0, 1, 2};
  int seq_fx[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    reset2 = 1; halt2 = 0; flush2 = 0; rr2 = 0; req2 = 0;
    data2 = {16'hBEEF, 16'h1234};
    reset3 = 1; halt3 = 0; flush3 = 0; rr3 = 0; req3 = 0;
    data3 = {16'h3333, 16'h2222, 16'h1111};
    tick();
    reset2 = 0; reset3 = 0;
    chk("rst_inst2", 32'(inst2), 0);
    chk("rst_vld2", 32'(vld2), 0);
    chk("rst_pend2", 32'(pend2), 0);
    chk("rst_pend3", 32'(pend3), 0);

    // single held request, 2 sources
    req2 = 2'b01;
    tick();
    chk("t1_pend", 32'(pend2), 1);
    chk("t1_vld_early", 32'(vld2), 0);
    tick();
    chk("t1_vld", 32'(vld2), 1);
    chk("t1_inst", 32'(inst2), 32'h1234);
    chk("t1_gid", 32'(gid2), 0);
    chk("t1_pend0", 32'(pend2), 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (vld2) pulses++;
    end
    chk("t1_extra", 32'(pulses), 0);
    req2 = 0;

    // fixed priority, 2 and 0 together
    req3 = 3'b101;
    tick();
    chk("fp_pend", 32'(pend3), 3'b101);
    req3 = 0;
    tick();
    chk("fp_vld_a", 32'(vld3), 1);
    chk("fp_gid_a", 32'(gid3), 0);
    chk("fp_inst_a", 32'(inst3), 32'h1111);
    tick();
    chk("fp_vld_b", 32'(vld3), 1);
    chk("fp_gid_b", 32'(gid3), 2);
    chk("fp_inst_b", 32'(inst3), 32'h3333);
    chk("fp_pend_b", 32'(pend3), 0);

    // round-robin with continuous re-pulsing
    rr3 = 1;
    req3 = 3'b111;
    tick();
    for (int i = 0; i < 6; i++) begin
      req3 = (i % 2 == 0) ? 3'b000 : 3'b111;
      tick();
      chk("rr_vld", 32'(vld3), 1);
      chk($sformatf("rr_gid%0d", i), 32'(gid3), 32'(seq_rr[i]));
    end
    req3 = 0; flush3 = 1;
    tick();
    flush3 = 0;
    chk("fl_vld", 32'(vld3), 0);
    chk("fl_pend", 32'(pend3), 0);
    chk("fl_ovr", 32'(ovr3), 0);

    // fixed priority, same stimulus: source 2 starves
    rr3 = 0;
    req3 = 3'b111;
    tick();
    for (int i = 0; i < 6; i++) begin
      req3 = (i % 2 == 0) ? 3'b000 : 3'b111;
      tick();
      chk($sformatf("fx_gid%0d", i), 32'(gid3), 32'(seq_fx[i]));
    end
    chk("fx_starve", 32'(pend3[2]), 1);
    req3 = 0; flush3 = 1;
    tick();
    flush3 = 0;

    // halt holds a pending request
    data3[31:16] = 16'h5555;
    halt3 = 1; req3 = 3'b010;
    tick();
    req3 = 0;
    tick();
    chk("h_pend", 32'(pend3), 3'b010);
    chk("h_vld", 32'(vld3), 0);
    chk("h_inst", 32'(inst3), 32'h2222);
    halt3 = 0;
    tick();
    chk("h_vld_go", 32'(vld3), 1);
    chk("h_gid", 32'(gid3), 1);
    chk("h_inst_go", 32'(inst3), 32'h5555);

    // overrun under halt, then flush
    halt3 = 1; req3 = 3'b001;
    tick();
    req3 = 0;
    tick();
    req3 = 3'b001;
    tick();
    req3 = 0;
    tick();
    chk("ov_ovr", 32'(ovr3), 3'b001);
    chk("ov_pend", 32'(pend3), 3'b001);
    halt3 = 0;
    tick();
    chk("ov_vld", 32'(vld3), 1);
    chk("ov_gid", 32'(gid3), 0);
    chk("ov_sticky", 32'(ovr3), 3'b001);
    tick();
    chk("ov_once", 32'(vld3), 0);
    flush3 = 1;
    tick();
    flush3 = 0;
    chk("ov_fl_ovr", 32'(ovr3), 0);
    chk("ov_fl_pend", 32'(pend3), 0);

    // reset mid-operation with req[0] held across it
    halt3 = 1; req3 = 3'b101;
    tick();
    chk("rs_pend_pre", 32'(pend3), 3'b101);
    req3 = 3'b001; reset3 = 1;
    tick();
    chk("rs_inst", 32'(inst3), 0);
    chk("rs_vld", 32'(vld3), 0);
    chk("rs_gid", 32'(gid3), 0);
    chk("rs_pend", 32'(pend3), 0);
    chk("rs_ovr", 32'(ovr3), 0);
    reset3 = 0; halt3 = 0; rr3 = 1; req3 = 3'b011;
    tick();
    chk("rs_pend_post", 32'(pend3), 3'b011);
    tick();
    chk("rs_gid_a", 32'(gid3), 0);
    chk("rs_vld_a", 32'(vld3), 1);
    tick();
    chk("rs_gid_b", 32'(gid3), 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vld3) pulses++;
    end
    chk("rs_extra", 32'(pulses), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
